// File: rtl/instruction_fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package instruction_fetch_pkg;

  localparam int          DEFAULT_NB_MEM_ADDR = 8;
  localparam logic [31:0] HALT_WORD           = 32'hFC00_0000;
  localparam logic [31:0] NOP_WORD            = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/instruction_memory.sv
// Program store: one synchronous write port, one combinational read port.
module instruction_memory #(
  parameter int NB_DATA     = 32,
  parameter int NB_MEM_ADDR = 8
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [NB_MEM_ADDR-1:0] waddr,
  input  logic [NB_DATA-1:0]     wdata,
  input  logic [NB_MEM_ADDR-1:0] raddr,
  output logic [NB_DATA-1:0]     rdata
);

  localparam int DEPTH = 1 << NB_MEM_ADDR;

  // No reset: the loaded program must survive a core reset.
  logic [NB_DATA-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: IDLE/RUN/HALT control, PC, and registered instruction output.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int NB_DATA     = 32,
  parameter int NB_MEM_ADDR = DEFAULT_NB_MEM_ADDR
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic                   i_load_we,
  input  logic [NB_MEM_ADDR-1:0] i_load_addr,
  input  logic [NB_DATA-1:0]     i_load_data,
  input  logic                   i_start,
  input  logic                   i_step_mode,
  input  logic                   i_step,
  input  logic                   i_stall,
  input  logic                   i_jump,
  input  logic [NB_DATA-1:0]     i_jump_addr,
  output logic [NB_DATA-1:0]     o_instruction,
  output logic [NB_DATA-1:0]     o_pcounter,
  output logic [NB_DATA-1:0]     o_pcounter4,
  output logic                   o_valid,
  output logic                   o_halt,
  output logic [1:0]             o_state
);

  localparam logic [NB_DATA-1:0] HALT_W = NB_DATA'(HALT_WORD);
  localparam logic [NB_DATA-1:0] NOP_W  = NB_DATA'(NOP_WORD);
  localparam logic [NB_DATA-1:0] FOUR   = NB_DATA'(4);
  localparam logic [NB_DATA-1:0] ALIGN  = ~NB_DATA'(3);

  fetch_state_e       state, next_state;
  logic [NB_DATA-1:0] pc;
  logic [NB_DATA-1:0] rd_data;
  logic               mem_we;
  logic               fetch_en;
  logic               jump_en;
  logic               is_halt;

  assign mem_we   = i_load_we && (state == ST_IDLE);
  assign fetch_en = (state == ST_RUN) && !i_stall && (!i_step_mode || i_step);
  assign jump_en  = (state == ST_RUN) && i_jump;
  assign is_halt  = (rd_data == HALT_W);
  assign o_state  = state;

  // PC bits above the word index are dropped, so fetches wrap around memory.
  instruction_memory #(
    .NB_DATA     (NB_DATA),
    .NB_MEM_ADDR (NB_MEM_ADDR)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (i_load_addr),
    .wdata (i_load_data),
    .raddr (pc[NB_MEM_ADDR+1:2]),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (i_start) next_state = ST_RUN;
      ST_RUN:  if (!jump_en && fetch_en && is_halt) next_state = ST_HALT;
      ST_HALT: next_state = ST_HALT;
      default: next_state = ST_IDLE;
    endcase
  end

  // A redirect beats any fetch, including one of the halt word.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      pc            <= '0;
      o_instruction <= '0;
      o_pcounter    <= '0;
      o_pcounter4   <= '0;
      o_valid       <= 1'b0;
      o_halt        <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (jump_en) begin
            pc            <= i_jump_addr & ALIGN;
            o_instruction <= NOP_W;
            o_valid       <= 1'b0;
          end else if (fetch_en) begin
            o_instruction <= rd_data;
            o_pcounter    <= pc;
            o_pcounter4   <= pc + FOUR;
            o_valid       <= 1'b1;
            if (is_halt) begin
              o_halt <= 1'b1;
            end else begin
              pc <= pc + FOUR;
            end
          end
        end
        default: begin
          o_instruction <= NOP_W;
          o_valid       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a per-cycle expected-output queue.
module tb_instruction_fetch;

  localparam int NB_DATA     = 32;
  localparam int NB_MEM_ADDR = 8;
  localparam logic [31:0] HALT = 32'hFC00_0000;

  logic                   clk = 1'b0;
  logic                   i_rst_n;
  logic                   i_load_we;
  logic [NB_MEM_ADDR-1:0] i_load_addr;
  logic [NB_DATA-1:0]     i_load_data;
  logic                   i_start;
  logic                   i_step_mode;
  logic                   i_step;
  logic                   i_stall;
  logic                   i_jump;
  logic [NB_DATA-1:0]     i_jump_addr;
  logic [NB_DATA-1:0]     o_instruction;
  logic [NB_DATA-1:0]     o_pcounter;
  logic [NB_DATA-1:0]     o_pcounter4;
  logic                   o_valid;
  logic                   o_halt;
  logic [1:0]             o_state;

  int checks = 0;
  int errors = 0;

  // Entry: {valid, pcounter, instruction} expected after the next edge.
  logic [64:0] exp_q[$];

  instruction_fetch #(
    .NB_DATA     (NB_DATA),
    .NB_MEM_ADDR (NB_MEM_ADDR)
  ) dut (
    .clk           (clk),
    .i_rst_n       (i_rst_n),
    .i_load_we     (i_load_we),
    .i_load_addr   (i_load_addr),
    .i_load_data   (i_load_data),
    .i_start       (i_start),
    .i_step_mode   (i_step_mode),
    .i_step        (i_step),
    .i_stall       (i_stall),
    .i_jump        (i_jump),
    .i_jump_addr   (i_jump_addr),
    .o_instruction (o_instruction),
    .o_pcounter    (o_pcounter),
    .o_pcounter4   (o_pcounter4),
    .o_valid       (o_valid),
    .o_halt        (o_halt),
    .o_state       (o_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1ns later, and score the queued expectation.
  task automatic cyc();
    logic [64:0] e;
    logic [31:0] p4;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (e[64]) begin
        chk("fetch_out", {o_valid, o_pcounter, o_instruction}, e);
        p4 = e[63:32] + 32'd4;
        chk("pcounter4", {33'd0, o_pcounter4}, {33'd0, p4});
      end else begin
        chk("bubble_out", {32'd0, o_valid, o_instruction}, {32'd0, e[64], e[31:0]});
      end
    end
  endtask

  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    exp_q.push_back({v, pc, ins});
    cyc();
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    i_load_we = 1'b1; i_load_addr = a; i_load_data = d;
    cyc();
    i_load_we = 1'b0;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    cyc();
    chk("rst_instr", {33'd0, o_instruction}, 65'd0);
    chk("rst_pc",    {33'd0, o_pcounter}, 65'd0);
    chk("rst_pc4",   {33'd0, o_pcounter4}, 65'd0);
    chk("rst_flags", {62'd0, o_valid, o_halt, o_state == 2'b00}, 65'd1);
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_rst_n = 1'b0; i_load_we = 1'b0; i_load_addr = '0; i_load_data = '0;
    i_start = 1'b0; i_step_mode = 1'b0; i_step = 1'b0; i_stall = 1'b0;
    i_jump = 1'b0; i_jump_addr = '0;
    #1;
    cyc();
    do_reset();

    // Basic program runs to HALT.
    load(8'd0, 32'h2001_0005);
    load(8'd1, 32'h2002_0007);
    load(8'd2, HALT);
    i_start = 1'b1;
    step(1'b0, 32'd0, 32'd0);
    i_start = 1'b0;
    chk("state_run", {63'd0, o_state}, 65'd1);
    step(1'b1, 32'd0, 32'h2001_0005);
    step(1'b1, 32'd4, 32'h2002_0007);
    step(1'b1, 32'd8, HALT);
    chk("halt_set", {62'd0, o_halt, o_state}, {62'd0, 1'b1, 2'b10});
    i_jump = 1'b1; i_jump_addr = 32'h40; i_start = 1'b1;
    step(1'b0, 32'd0, 32'd0);
    i_jump = 1'b0; i_start = 1'b0;
    chk("halt_hold", {62'd0, o_halt, o_state}, {62'd0, 1'b1, 2'b10});

    // Reset in HALT wins over start; program is retained.
    i_start = 1'b1;
    do_reset();
    i_start = 1'b0;

    // Jump in IDLE ignored; stall holds; loads during RUN ignored.
    i_jump = 1'b1; i_jump_addr = 32'h40;
    load(8'd2, 32'h2003_0009);
    i_jump = 1'b0;
    load(8'd3, 32'h2004_000B);
    load(8'd4, HALT);
    i_start = 1'b1;
    step(1'b0, 32'd0, 32'd0);
    i_start = 1'b0;
    step(1'b1, 32'd0, 32'h2001_0005);
    i_stall = 1'b1;
    i_load_we = 1'b1; i_load_addr = 8'd1; i_load_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) step(1'b1, 32'd0, 32'h2001_0005);
    i_stall = 1'b0; i_load_we = 1'b0;
    step(1'b1, 32'd4, 32'h2002_0007);
    // Jump under stall still redirects, aligned down to 0xC.
    i_jump = 1'b1; i_jump_addr = 32'h0000_000E; i_stall = 1'b1;
    step(1'b0, 32'd0, 32'd0);
    i_jump = 1'b0; i_stall = 1'b0;
    step(1'b1, 32'hC, 32'h2004_000B);
    step(1'b1, 32'h10, HALT);
    step(1'b0, 32'd0, 32'd0);
    chk("halt_b", {63'd0, o_state}, 65'd2);

    // Step mode: pulses on cycles 5 and 9 after start.
    do_reset();
    i_step_mode = 1'b1;
    i_start = 1'b1;
    step(1'b0, 32'd0, 32'd0);
    i_start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      i_step = (c == 5 || c == 9);
      if (c < 5)      step(1'b0, 32'd0, 32'd0);
      else if (c < 9) step(1'b1, 32'd0, 32'h2001_0005);
      else            step(1'b1, 32'd4, 32'h2002_0007);
    end
    i_step = 1'b0; i_step_mode = 1'b0;

    // Jump coincident with HALT fetch wins; alignment and PC wrap.
    do_reset();
    load(8'd0, HALT);
    load(8'd255, 32'h1234_5678);
    i_start = 1'b1;
    step(1'b0, 32'd0, 32'd0);
    i_start = 1'b0;
    i_jump = 1'b1; i_jump_addr = 32'd8;
    step(1'b0, 32'd0, 32'd0);
    chk("jump_beats_halt", {62'd0, o_halt, o_state}, {62'd0, 1'b0, 2'b01});
    i_jump = 1'b0;
    step(1'b1, 32'd8, 32'h2003_0009);
    i_jump = 1'b1; i_jump_addr = 32'h0000_0405;
    step(1'b0, 32'd0, 32'd0);
    i_jump = 1'b0;
    step(1'b1, 32'h404, 32'h2002_0007);
    i_jump = 1'b1; i_jump_addr = 32'hFFFF_FFFE;
    step(1'b0, 32'd0, 32'd0);
    i_jump = 1'b0;
    step(1'b1, 32'hFFFF_FFFC, 32'h1234_5678);
    step(1'b1, 32'd0, HALT);
    chk("halt_e", {62'd0, o_halt, o_state}, {62'd0, 1'b1, 2'b10});

    chk("queue_drained", {33'd0, 32'(exp_q.size())}, 65'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
